// File: rtl/wm_billing_ctrl.sv
// wm_billing_ctrl: billing and run controller for the washing-machine front panel.
//
// The controller checks the user balance against a per-mode price table,
// deducts the fee, counts the wash duration down in seconds, and drives the
// state LEDs and four BCD digits for the 4-digit scan driver.
// Digit code 4'hB is blank and 4'hE shows the letter E.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-low reset
//   on         machine power/enable level; low forces IDLE
//   start      single-cycle start request
//   mode       requested wash mode
//   bal        current user balance
//   bal_rem    balance after the last successful charge
//   fee        fee charged for the current/last run
//   secs_left  remaining run seconds
//   busy       high while running
//   done       one-cycle pulse when a run completes
//   err        high in the error state
//   st_light   one-hot state LEDs (RUN 0x80, IDLE 0x40, DONE 0x20, ERR 0x10)
//   disp       four BCD digits {d3,d2,d1,d0}
//
// Handshake: start is a level sampled on each rising clk edge and acts only
// in IDLE/DONE/ERR with on=1. It needs no acknowledge; in RUN it is ignored.
// All outputs are registered and computed from the next-state values, so they
// show the state the controller has just entered. st_light doubles as the
// observable FSM state.
module wm_billing_ctrl #(
    parameter int MODE_W        = 2,
    parameter int N_MODES       = 4,
    parameter int BAL_W         = 12,
    parameter int TICKS_PER_SEC = 100_000_000,
    parameter logic [N_MODES*7-1:0] PRICES = {7'd8, 7'd6, 7'd4, 7'd3},
    parameter logic [N_MODES*7-1:0] DURS   = {7'd60, 7'd45, 7'd30, 7'd20}
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              on,
    input  logic              start,
    input  logic [MODE_W-1:0] mode,
    input  logic [BAL_W-1:0]  bal,
    output logic [BAL_W-1:0]  bal_rem,
    output logic [6:0]        fee,
    output logic [6:0]        secs_left,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [7:0]        st_light,
    output logic [15:0]       disp
);

    localparam int TICK_W = $clog2(TICKS_PER_SEC);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(TICKS_PER_SEC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE,
        S_ERR
    } state_t;

    state_t              state_q, state_d;
    logic [TICK_W-1:0]   tick_q, tick_d;
    logic [MODE_W-1:0]   mode_q, mode_d;
    logic [BAL_W-1:0]    bal_rem_d;
    logic [6:0]          fee_d;
    logic [6:0]          secs_d;
    logic                done_d;
    logic [7:0]          st_light_d;
    logic [15:0]         disp_d;

    logic [6:0]          sel_price;
    logic [6:0]          sel_dur;
    logic                mode_ok;
    logic                can_pay;

    // Two BCD digits of a value 0..99.
    function automatic logic [7:0] bcd2(input logic [6:0] v);
        return {4'(v / 7'd10), 4'(v % 7'd10)};
    endfunction

    // Table lookup for the live mode input; an out-of-range mode matches no
    // entry and leaves mode_ok low.
    always_comb begin
        sel_price = '0;
        sel_dur   = '0;
        mode_ok   = 1'b0;
        for (int i = 0; i < N_MODES; i++) begin
            if (mode == MODE_W'(i)) begin
                mode_ok   = 1'b1;
                sel_price = PRICES[i*7 +: 7];
                sel_dur   = DURS[i*7 +: 7];
            end
        end
    end

    assign can_pay = mode_ok && (bal >= BAL_W'(sel_price));

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state_q;
        tick_d    = tick_q;
        mode_d    = mode_q;
        bal_rem_d = bal_rem;
        fee_d     = fee;
        secs_d    = secs_left;
        done_d    = 1'b0;

        if (!on) begin
            // Power off wins over everything; the charge is not refunded.
            state_d = S_IDLE;
            secs_d  = '0;
            tick_d  = '0;
        end else begin
            case (state_q)
                S_RUN: begin
                    if (tick_q == TICK_MAX) begin
                        tick_d = '0;
                        secs_d = secs_left - 7'd1;
                        if (secs_left == 7'd1) begin
                            state_d = S_DONE;
                            done_d  = 1'b1;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                default: begin
                    // IDLE, DONE and ERR all accept a new start.
                    if (start) begin
                        if (can_pay) begin
                            state_d   = S_RUN;
                            fee_d     = sel_price;
                            bal_rem_d = bal - BAL_W'(sel_price);
                            secs_d    = sel_dur;
                            tick_d    = '0;
                            mode_d    = mode;
                        end else begin
                            state_d = S_ERR;
                        end
                    end
                end
            endcase
        end

        case (state_d)
            S_RUN:   st_light_d = 8'b1000_0000;
            S_DONE:  st_light_d = 8'b0010_0000;
            S_ERR:   st_light_d = 8'b0001_0000;
            default: st_light_d = 8'b0100_0000;
        endcase

        if (!on) begin
            disp_d = 16'hBBBB;
        end else begin
            case (state_d)
                S_RUN:   disp_d = {4'(mode_d), 4'hB, bcd2(secs_d)};
                S_DONE:  disp_d = 16'hBB00;
                S_ERR:   disp_d = 16'hEBBB;
                default: disp_d = mode_ok ? {8'hBB, bcd2(sel_price)} : 16'hBBBB;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            tick_q    <= '0;
            mode_q    <= '0;
            bal_rem   <= '0;
            fee       <= '0;
            secs_left <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            st_light  <= 8'b0100_0000;
            disp      <= 16'hBBBB;
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            mode_q    <= mode_d;
            bal_rem   <= bal_rem_d;
            fee       <= fee_d;
            secs_left <= secs_d;
            busy      <= (state_d == S_RUN);
            done      <= done_d;
            err       <= (state_d == S_ERR);
            st_light  <= st_light_d;
            disp      <= disp_d;
        end
    end

endmodule
